// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand collector: state encoding, opcodes,
// the per-opcode required-operand mask and the opcode legality check.
package alu_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Arithmetic opcodes (MODE=1)
    localparam int unsigned ARITH_ADD     = 0;
    localparam int unsigned ARITH_SUB     = 1;
    localparam int unsigned ARITH_ADD_CIN = 2;
    localparam int unsigned ARITH_SUB_CIN = 3;
    localparam int unsigned ARITH_INC_A   = 4;
    localparam int unsigned ARITH_DEC_A   = 5;
    localparam int unsigned ARITH_INC_B   = 6;
    localparam int unsigned ARITH_DEC_B   = 7;
    localparam int unsigned ARITH_CMP     = 8;
    localparam int unsigned ARITH_MUL_INC = 9;
    localparam int unsigned ARITH_MUL_SHL = 10;
    localparam int unsigned ARITH_MAX_OP  = ARITH_MUL_SHL;

    // Logical opcodes (MODE=0)
    localparam int unsigned LOGIC_AND    = 0;
    localparam int unsigned LOGIC_NAND   = 1;
    localparam int unsigned LOGIC_OR     = 2;
    localparam int unsigned LOGIC_NOR    = 3;
    localparam int unsigned LOGIC_XOR    = 4;
    localparam int unsigned LOGIC_XNOR   = 5;
    localparam int unsigned LOGIC_NOT_A  = 6;
    localparam int unsigned LOGIC_NOT_B  = 7;
    localparam int unsigned LOGIC_SHR1_A = 8;
    localparam int unsigned LOGIC_SHL1_A = 9;
    localparam int unsigned LOGIC_SHR1_B = 10;
    localparam int unsigned LOGIC_SHL1_B = 11;
    localparam int unsigned LOGIC_ROL    = 12;
    localparam int unsigned LOGIC_ROR    = 13;
    localparam int unsigned LOGIC_MAX_OP = LOGIC_ROR;

    // Operand masks: bit 1 = OPA, bit 0 = OPB
    localparam logic [1:0] NEED_AB = 2'b11;
    localparam logic [1:0] NEED_A  = 2'b10;
    localparam logic [1:0] NEED_B  = 2'b01;

    // Operands an opcode consumes; unknown codes conservatively need both.
    function automatic logic [1:0] req_mask(input logic mode, input int unsigned cmd);
        logic [1:0] need;
        need = NEED_AB;
        if (mode) begin
            case (cmd)
                ARITH_INC_A, ARITH_DEC_A: need = NEED_A;
                ARITH_INC_B, ARITH_DEC_B: need = NEED_B;
                default:                  need = NEED_AB;
            endcase
        end else begin
            case (cmd)
                LOGIC_NOT_A, LOGIC_SHR1_A, LOGIC_SHL1_A: need = NEED_A;
                LOGIC_NOT_B, LOGIC_SHR1_B, LOGIC_SHL1_B: need = NEED_B;
                default:                                 need = NEED_AB;
            endcase
        end
        return need;
    endfunction

    function automatic logic cmd_legal(input logic mode, input int unsigned cmd);
        return mode ? (cmd <= ARITH_MAX_OP) : (cmd <= LOGIC_MAX_OP);
    endfunction

endpackage

// File: rtl/alu_operand_collector.sv
// Collects OPA/OPB beats for one ALU command and issues a registered operation,
// with a missing-operand timeout. Define ALU_OPCODE_CHECK_EN to flag illegal opcodes.
module alu_operand_collector
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned CMD_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CE,
    input  logic [1:0]           IN_VALID,
    input  logic [WIDTH-1:0]     OPA_IN,
    input  logic [WIDTH-1:0]     OPB_IN,
    input  logic [CMD_WIDTH-1:0] CMD_IN,
    input  logic                 MODE_IN,
    input  logic                 CIN_IN,
    output logic                 IN_READY,
    output logic [WIDTH-1:0]     OPA,
    output logic [WIDTH-1:0]     OPB,
    output logic [CMD_WIDTH-1:0] CMD,
    output logic                 MODE,
    output logic                 CIN,
    output logic [1:0]           INP_VALID,
    output logic                 ISSUE,
    output logic                 TMO_ERR,
    output logic                 CMD_ERR
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [1:0]           have_q, have_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
    logic                 mode_q, mode_d, cin_q, cin_d;

    logic [WIDTH-1:0]     opa_q, opa_d, opb_q, opb_d;
    logic [CMD_WIDTH-1:0] ocmd_q, ocmd_d;
    logic                 omode_q, omode_d, ocin_q, ocin_d;
    logic [1:0]           oiv_q, oiv_d;
    logic                 issue_q, issue_d, tmo_q, tmo_d, cerr_q, cerr_d;

    logic                 is_idle;
    logic [1:0]           have_nx, need_c;
    logic [WIDTH-1:0]     a_nx, b_nx;
    logic [CMD_WIDTH-1:0] cmd_nx;
    logic                 mode_nx, cin_nx;
    logic                 covered_c, bad_c, tmo_c, fire_c;

    // Operation as it would look after merging this cycle's beat
    assign is_idle   = (state_q == ST_IDLE);
    assign have_nx   = is_idle ? IN_VALID : (have_q | IN_VALID);
    assign a_nx      = IN_VALID[1] ? OPA_IN : (is_idle ? '0 : a_q);
    assign b_nx      = IN_VALID[0] ? OPB_IN : (is_idle ? '0 : b_q);
    assign cmd_nx    = is_idle ? CMD_IN  : cmd_q;
    assign mode_nx   = is_idle ? MODE_IN : mode_q;
    assign cin_nx    = is_idle ? CIN_IN  : cin_q;
    assign need_c    = req_mask(mode_nx, 32'(cmd_nx));
    assign covered_c = ((have_nx & need_c) == need_c);

`ifdef ALU_OPCODE_CHECK_EN
    assign bad_c = is_idle && !cmd_legal(MODE_IN, 32'(CMD_IN));
`else
    assign bad_c = 1'b0;
`endif

    // Completion on the last WAIT cycle wins over the timeout
    assign tmo_c  = !is_idle && (count_q == CNT_LAST) && !covered_c;
    assign fire_c = CE && (is_idle ? ((|IN_VALID) && (covered_c || bad_c))
                                   : (covered_c || tmo_c));

    assign IN_READY = CE;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            have_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cmd_q   <= '0;
            mode_q  <= 1'b0;
            cin_q   <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            ocmd_q  <= '0;
            omode_q <= 1'b0;
            ocin_q  <= 1'b0;
            oiv_q   <= '0;
            issue_q <= 1'b0;
            tmo_q   <= 1'b0;
            cerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            have_q  <= have_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cmd_q   <= cmd_d;
            mode_q  <= mode_d;
            cin_q   <= cin_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            ocmd_q  <= ocmd_d;
            omode_q <= omode_d;
            ocin_q  <= ocin_d;
            oiv_q   <= oiv_d;
            issue_q <= issue_d;
            tmo_q   <= tmo_d;
            cerr_q  <= cerr_d;
        end
    end

    // Next state and collection registers
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        have_d  = have_q;
        a_d     = a_q;
        b_d     = b_q;
        cmd_d   = cmd_q;
        mode_d  = mode_q;
        cin_d   = cin_q;
        if (CE) begin
            if (is_idle) begin
                if (|IN_VALID) begin
                    have_d  = have_nx;
                    a_d     = a_nx;
                    b_d     = b_nx;
                    cmd_d   = cmd_nx;
                    mode_d  = mode_nx;
                    cin_d   = cin_nx;
                    count_d = '0;
                    if (!fire_c) begin
                        state_d = ST_WAIT;
                    end
                end
            end else begin
                have_d  = have_nx;
                a_d     = a_nx;
                b_d     = b_nx;
                count_d = count_q + CNT_W'(1);
                if (fire_c) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            end
        end
    end

    // Issued operation: payload holds between issues, flags pulse
    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        ocmd_d  = ocmd_q;
        omode_d = omode_q;
        ocin_d  = ocin_q;
        oiv_d   = oiv_q;
        issue_d = 1'b0;
        tmo_d   = 1'b0;
        cerr_d  = 1'b0;
        if (fire_c) begin
            opa_d   = a_nx;
            opb_d   = b_nx;
            ocmd_d  = cmd_nx;
            omode_d = mode_nx;
            ocin_d  = cin_nx;
            oiv_d   = have_nx;
            issue_d = 1'b1;
            tmo_d   = tmo_c;
            cerr_d  = bad_c;
        end
    end

    assign OPA       = opa_q;
    assign OPB       = opb_q;
    assign CMD       = ocmd_q;
    assign MODE      = omode_q;
    assign CIN       = ocin_q;
    assign INP_VALID = oiv_q;
    assign ISSUE     = issue_q;
    assign TMO_ERR   = tmo_q;
    assign CMD_ERR   = cerr_q;

endmodule
